// File: rtl/led_blink_bank.sv
// Bank of independent LED channels. Each channel has a free-running counter and
// drives a registered LED that can be off, on, blinking from a counter tap, or PWM.
module led_blink_bank #(
    parameter int N_CH     = 3,
    parameter int CNT_W    = 32,
    parameter int TAP_BASE = 20,
    parameter int PWM_W    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0]       cnt_clr,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [2*N_CH-1:0]     tap_sel,
    input  logic [PWM_W*N_CH-1:0] duty,
    output logic [N_CH-1:0]       LED,
    output logic [N_CH-1:0]       wrap
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_BLINK = 2'b01;
    localparam logic [1:0] MODE_PWM   = 2'b10;
    localparam logic [1:0] MODE_ON    = 2'b11;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [1:0]       ch_mode;
        logic [1:0]       ch_tap;
        logic [PWM_W-1:0] ch_duty;
        logic             led_next;
        logic             led_q;
        logic             wrap_q;

        assign ch_mode = mode[2*i +: 2];
        assign ch_tap  = tap_sel[2*i +: 2];
        assign ch_duty = duty[PWM_W*i +: PWM_W];

        // LED level is decided from the count as it stands before this edge.
        always_comb begin
            // NOTE: default first so every path assigns led_next and no latch is inferred.
            led_next = 1'b0;
            case (ch_mode)
                MODE_OFF:   led_next = 1'b0;
                MODE_BLINK: led_next = cnt[TAP_BASE + int'(ch_tap)];
                MODE_PWM:   led_next = (cnt[PWM_W-1:0] < ch_duty);
                MODE_ON:    led_next = 1'b1;
                default:    led_next = 1'b0;
            endcase
        end

        always_ff @(posedge CLK) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (RST) begin
                cnt    <= '0;
                led_q  <= 1'b0;
                wrap_q <= 1'b0;
            end else begin
                led_q  <= led_next;
                wrap_q <= 1'b0;
                if (cnt_clr[i]) begin
                    cnt <= '0;
                end else if (ch_en[i]) begin
                    cnt    <= cnt + CNT_W'(1);
                    wrap_q <= &cnt;
                end
            end
        end

        assign LED[i]  = led_q;
        assign wrap[i] = wrap_q;
    end

endmodule

// File: tb/tb_led_blink_bank.sv
// Directed bench for led_blink_bank with N_CH=3, CNT_W=8, TAP_BASE=2, PWM_W=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_led_blink_bank;

    localparam int N_CH     = 3;
    localparam int CNT_W    = 8;
    localparam int TAP_BASE = 2;
    localparam int PWM_W    = 4;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [N_CH-1:0]       ch_en;
    logic [N_CH-1:0]       cnt_clr;
    logic [2*N_CH-1:0]     mode;
    logic [2*N_CH-1:0]     tap_sel;
    logic [PWM_W*N_CH-1:0] duty;
    logic [N_CH-1:0]       LED;
    logic [N_CH-1:0]       wrap;

    int checks   = 0;
    int failures = 0;

    led_blink_bank #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TAP_BASE(TAP_BASE), .PWM_W(PWM_W)
    ) dut (
        .CLK(CLK), .RST(RST), .ch_en(ch_en), .cnt_clr(cnt_clr), .mode(mode),
        .tap_sel(tap_sel), .duty(duty), .LED(LED), .wrap(wrap)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One reset edge; the first edge after this returns is the first counting edge.
    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        int hi;
        int n0;
        int first;
        int second;
        int other;

        RST = 1'b1; ch_en = 3'b111; cnt_clr = '0; mode = 6'b111111; tap_sel = '0; duty = '0;

        // Reset held two cycles with everything enabled and forced on.
        tick();
        check("rst_led_1", LED, 0);
        check("rst_wrap_1", wrap, 0);
        tick();
        check("rst_led_2", LED, 0);
        check("rst_wrap_2", wrap, 0);
        RST = 1'b0;
        tick();
        check("release_led_on", LED, 3'b111);
        check("release_wrap", wrap, 0);

        // Blink on bit 2: 4 low, 4 high.
        ch_en = 3'b001; mode = 6'b000001; tap_sel = '0;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("blink_tap0", LED[0], ((k - 1) >> 2) & 1);
        end

        // Blink on bit 5: period 64, first rise after 32 low cycles.
        tap_sel = 6'b000011;
        do_reset();
        hi = 0;
        for (int k = 1; k <= 128; k++) begin
            tick();
            if (LED[0]) hi++;
            if (k == 32) check("blink_tap3_low", LED[0], 0);
            if (k == 33) check("blink_tap3_rise", LED[0], 1);
        end
        check("blink_tap3_high_cycles", hi, 64);

        // Wrap pulses over 512 enabled cycles.
        mode = '0; tap_sel = '0; ch_en = 3'b001;
        do_reset();
        n0 = 0; first = 0; second = 0; other = 0;
        for (int k = 1; k <= 512; k++) begin
            tick();
            if (wrap[0]) begin
                n0++;
                if (n0 == 1) first = k;
                else if (n0 == 2) second = k;
            end
            if (wrap[1] || wrap[2]) other++;
        end
        check("wrap0_pulses", n0, 2);
        check("wrap0_first", first, 256);
        check("wrap0_spacing", second - first, 256);
        check("wrap12_idle", other, 0);

        // PWM on channel 1.
        mode = 6'b001000; ch_en = 3'b010; duty = 12'h040;
        do_reset();
        hi = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (LED[1]) hi++;
            if (k == 1) check("pwm4_start_high", LED[1], 1);
            if (k == 5) check("pwm4_fall", LED[1], 0);
        end
        check("pwm4_high_cycles", hi, 8);
        duty = 12'h000;
        hi = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (LED[1]) hi++;
        end
        check("pwm0_high_cycles", hi, 0);
        duty = 12'h0F0;
        hi = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (LED[1]) hi++;
        end
        check("pwm15_high_cycles", hi, 30);

        // Clear dominates enable on an all-ones counter and suppresses wrap.
        mode = '0; duty = '0; tap_sel = '0; ch_en = 3'b100;
        do_reset();
        repeat (255) tick();
        check("ch2_pre_clear_wrap", wrap[2], 0);
        cnt_clr = 3'b100;
        tick();
        check("ch2_clear_no_wrap", wrap[2], 0);
        cnt_clr = '0; ch_en = '0; mode = 6'b100000; duty = 12'h100;
        tick();
        check("ch2_cleared_pwm", LED[2], 1);
        check("ch2_cleared_wrap", wrap[2], 0);
        mode = 6'b010000; tap_sel = 6'b110000;
        tick();
        check("ch2_cleared_bit5", LED[2], 0);

        // Freeze mid-blink, then mode changes leave the count alone.
        mode = 6'b010000; tap_sel = '0; duty = '0; ch_en = 3'b100;
        do_reset();
        repeat (6) tick();
        check("ch2_blink_before_freeze", LED[2], 1);
        ch_en = '0;
        hi = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (LED[2]) hi++;
        end
        check("ch2_frozen_level", hi, 10);
        mode = 6'b110000;
        tick();
        check("ch2_frozen_on", LED[2], 1);
        mode = 6'b000000;
        tick();
        check("ch2_frozen_off", LED[2], 0);
        mode = 6'b010000;
        tick();
        check("ch2_frozen_blink_again", LED[2], 1);
        ch_en = 3'b100;
        tick();
        check("ch2_resume_cnt6", LED[2], 1);
        tick();
        check("ch2_resume_cnt7", LED[2], 1);
        tick();
        check("ch2_resume_cnt8", LED[2], 0);

        // One-cycle reset in the middle of PWM on all channels.
        mode = 6'b101010; duty = 12'h888; tap_sel = '0; ch_en = 3'b111;
        do_reset();
        repeat (20) tick();
        RST = 1'b1;
        tick();
        check("midrst_led", LED, 0);
        check("midrst_wrap", wrap, 0);
        RST = 1'b0;
        tick();
        check("midrst_restart_cnt0", LED, 3'b111);
        for (int k = 2; k <= 9; k++) begin
            tick();
            if (k == 8) check("midrst_cnt7", LED, 3'b111);
            if (k == 9) check("midrst_cnt8", LED, 3'b000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
